// File: rtl/gf180mcu_fd_sc_mcu9t5v0__inv_pipe.sv
// Polarity-programmable WIDTH-lane inverter feeding a DEPTH-stage elastic
// register pipeline with valid/ready handshaking on both sides.
module gf180mcu_fd_sc_mcu9t5v0__inv_pipe #(
  parameter int               WIDTH    = 4,
  parameter int               DEPTH    = 2,
  parameter logic [WIDTH-1:0] INV_MASK = {WIDTH{1'b1}},
  parameter int               OCC_W    = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] I,
  input  logic             I_VALID,
  output logic             I_READY,
  input  logic             POL_N,
  output logic [WIDTH-1:0] ZN,
  output logic             ZN_VALID,
  input  logic             ZN_READY,
  output logic [OCC_W-1:0] OCC
);

  logic [WIDTH-1:0] data_q  [DEPTH];
  logic [WIDTH-1:0] data_d  [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [DEPTH-1:0] adv;
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;
  logic             accept;
  logic             deliver;
  logic             allFull;

  // A stage may advance unless it and every stage downstream of it is full
  // while the output is stalled; written flat to keep the ready chain acyclic.
  always_comb begin
    adv = '0;
    for (int k = 0; k < DEPTH; k++) begin
      allFull = 1'b1;
      for (int j = k; j < DEPTH; j++) begin
        allFull = allFull & valid_q[j];
      end
      adv[k] = ZN_READY | ~allFull;
    end
  end

  // Polarity is folded in at capture so in-flight beats keep their transform.
  always_comb begin
    valid_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      data_d[k] = '0;
    end
    valid_d[0] = I_VALID;
    data_d[0]  = I ^ (INV_MASK & {WIDTH{~POL_N}});
    for (int k = 1; k < DEPTH; k++) begin
      valid_d[k] = valid_q[k-1];
      data_d[k]  = data_q[k-1];
    end
  end

  assign accept  = I_VALID & adv[0];
  assign deliver = valid_q[DEPTH-1] & ZN_READY;

  always_comb begin
    occ_d = occ_q;
    case ({accept, deliver})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q <= '0;
      occ_q   <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      occ_q <= occ_d;
      for (int k = 0; k < DEPTH; k++) begin
        if (adv[k]) begin
          valid_q[k] <= valid_d[k];
          if (valid_d[k]) begin
            data_q[k] <= data_d[k];
          end
        end
      end
    end
  end

  assign I_READY  = adv[0];
  assign ZN       = data_q[DEPTH-1];
  assign ZN_VALID = valid_q[DEPTH-1];
  assign OCC      = occ_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__inv_pipe.sv
// Self-checking bench: a FIFO-with-latency model of the default pipeline plus
// a one-cycle register model of a masked DEPTH=1 instance, under random traffic.
module tb_gf180mcu_fd_sc_mcu9t5v0__inv_pipe;

  localparam int DEPTH  = 2;
  localparam logic [3:0] MASK2 = 4'b0101;

  logic       CLK;
  logic       RST;
  logic [3:0] iData;
  logic       iValid;
  logic       polN;
  logic       zReady;
  logic       iReady;
  logic [3:0] zn;
  logic       znValid;
  logic [1:0] occ;

  logic       zReady2;
  logic       iReady2;
  logic [3:0] zn2;
  logic       znValid2;
  logic [0:0] occ2;

  int testCount = 0;
  int failCount = 0;
  int cyc = 0;

  typedef struct {
    logic [3:0] val;
    int         acc;
  } beat_t;

  beat_t sb[$];

  logic       exp2Valid = 1'b0;
  logic [3:0] exp2Data  = 4'h0;

  gf180mcu_fd_sc_mcu9t5v0__inv_pipe #(.WIDTH(4), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .I(iData), .I_VALID(iValid), .I_READY(iReady),
    .POL_N(polN), .ZN(zn), .ZN_VALID(znValid), .ZN_READY(zReady), .OCC(occ)
  );

  gf180mcu_fd_sc_mcu9t5v0__inv_pipe #(.WIDTH(4), .DEPTH(1), .INV_MASK(MASK2)) dutMask (
    .CLK(CLK), .RST(RST), .I(iData), .I_VALID(iValid), .I_READY(iReady2),
    .POL_N(polN), .ZN(zn2), .ZN_VALID(znValid2), .ZN_READY(zReady2), .OCC(occ2)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] d, input logic p, input logic r);
    @(posedge CLK);
    #1;
    iValid = v;
    iData  = d;
    polN   = p;
    zReady = r;
  endtask

  // Model of the default instance: an ordered queue of accepted beats, each
  // becoming visible at the head DEPTH cycles after acceptance.
  always @(negedge CLK) begin
    logic expValid;
    logic expReady;
    if (RST) begin
      sb.delete();
      checkOutput("rst_zn", 32'(zn), 32'h0);
      checkOutput("rst_zn_valid", 32'(znValid), 32'h0);
      checkOutput("rst_occ", 32'(occ), 32'h0);
      checkOutput("rst_i_ready", 32'(iReady), 32'h1);
    end else begin
      expValid = (sb.size() > 0) && (cyc - sb[0].acc >= DEPTH);
      expReady = zReady || (sb.size() < DEPTH);
      checkOutput("zn_valid", 32'(znValid), 32'(expValid));
      if (expValid) checkOutput("zn_data", 32'(zn), 32'(sb[0].val));
      checkOutput("occ", 32'(occ), 32'(sb.size()));
      checkOutput("i_ready", 32'(iReady), 32'(expReady));
      if (expValid && zReady) void'(sb.pop_front());
      if (iValid && expReady) sb.push_back('{iData ^ {4{~polN}}, cyc});
    end
  end

  // Model of the masked DEPTH=1 instance, whose output is always ready.
  always @(negedge CLK) begin
    if (RST) begin
      checkOutput("m_rst_zn", 32'(zn2), 32'h0);
      checkOutput("m_rst_valid", 32'(znValid2), 32'h0);
      exp2Valid = 1'b0;
      exp2Data  = 4'h0;
    end else begin
      checkOutput("m_valid", 32'(znValid2), 32'(exp2Valid));
      checkOutput("m_zn", 32'(zn2), 32'(exp2Data));
      checkOutput("m_occ", 32'(occ2), 32'(exp2Valid));
      checkOutput("m_i_ready", 32'(iReady2), 32'h1);
      exp2Valid = iValid;
      if (iValid) exp2Data = iData ^ (MASK2 & {4{~polN}});
    end
  end

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
  endtask

  initial begin
    RST = 1'b1; iValid = 1'b0; iData = 4'h0; polN = 1'b0; zReady = 1'b1; zReady2 = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;

    // Streaming 3, A, F with inversion
    applyStimulus(1'b1, 4'h3, 1'b0, 1'b1);
    applyStimulus(1'b1, 4'hA, 1'b0, 1'b1);
    applyStimulus(1'b1, 4'hF, 1'b0, 1'b1);
    @(negedge CLK);
    checkOutput("stream_zn0", 32'(zn), 32'hC);
    checkOutput("stream_occ0", 32'(occ), 32'h2);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
    @(negedge CLK);
    checkOutput("stream_zn1", 32'(zn), 32'h5);
    checkOutput("stream_occ1", 32'(occ), 32'h2);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
    @(negedge CLK);
    checkOutput("stream_zn2", 32'(zn), 32'h0);
    checkOutput("stream_valid2", 32'(znValid), 32'h1);
    checkOutput("stream_occ2", 32'(occ), 32'h1);
    drain(2);

    // Per-beat polarity
    applyStimulus(1'b1, 4'h6, 1'b0, 1'b1);
    applyStimulus(1'b1, 4'h6, 1'b1, 1'b1);
    applyStimulus(1'b1, 4'h6, 1'b0, 1'b1);
    @(negedge CLK);
    checkOutput("pol_zn0", 32'(zn), 32'h9);
    applyStimulus(1'b0, 4'h6, 1'b1, 1'b1);
    @(negedge CLK);
    checkOutput("pol_zn1", 32'(zn), 32'h6);
    applyStimulus(1'b0, 4'h6, 1'b1, 1'b1);
    @(negedge CLK);
    checkOutput("pol_zn2", 32'(zn), 32'h9);
    drain(2);

    // Polarity toggled while the head beat is stalled
    applyStimulus(1'b1, 4'h6, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'h6, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'h6, 1'b1, 1'b0);
    @(negedge CLK);
    checkOutput("stall_zn0", 32'(zn), 32'h9);
    applyStimulus(1'b0, 4'h6, 1'b0, 1'b0);
    @(negedge CLK);
    checkOutput("stall_zn1", 32'(zn), 32'h9);
    checkOutput("stall_valid", 32'(znValid), 32'h1);
    drain(3);

    // Backpressure until full, then simultaneous accept and deliver
    applyStimulus(1'b1, 4'h1, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h2, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h3, 1'b0, 1'b0);
    @(negedge CLK);
    checkOutput("full_i_ready", 32'(iReady), 32'h0);
    checkOutput("full_occ", 32'(occ), 32'h2);
    checkOutput("full_zn", 32'(zn), 32'hE);
    applyStimulus(1'b1, 4'h3, 1'b0, 1'b0);
    @(negedge CLK);
    checkOutput("full_zn_hold", 32'(zn), 32'hE);
    checkOutput("full_i_ready_hold", 32'(iReady), 32'h0);
    applyStimulus(1'b1, 4'h3, 1'b0, 1'b1);
    @(negedge CLK);
    checkOutput("full_release_ready", 32'(iReady), 32'h1);
    checkOutput("full_release_occ", 32'(occ), 32'h2);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
    @(negedge CLK);
    checkOutput("full_after_occ", 32'(occ), 32'h2);
    checkOutput("full_after_zn", 32'(zn), 32'hD);
    drain(3);

    // Masked DEPTH=1 instance
    applyStimulus(1'b1, 4'hF, 1'b0, 1'b1);
    applyStimulus(1'b1, 4'hF, 1'b1, 1'b1);
    @(negedge CLK);
    checkOutput("mask_zn_inv", 32'(zn2), 32'hA);
    checkOutput("mask_valid", 32'(znValid2), 32'h1);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
    @(negedge CLK);
    checkOutput("mask_zn_pass", 32'(zn2), 32'hF);
    drain(3);

    // Random traffic with bubbles and backpressure
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
    end
    drain(3);

    // Asynchronous reset with two beats in flight
    applyStimulus(1'b1, 4'h1, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h2, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    @(negedge CLK);
    checkOutput("pre_rst_occ", 32'(occ), 32'h2);
    #3 RST = 1'b1;
    #1;
    checkOutput("async_rst_zn", 32'(zn), 32'h0);
    checkOutput("async_rst_valid", 32'(znValid), 32'h0);
    checkOutput("async_rst_occ", 32'(occ), 32'h0);
    checkOutput("async_rst_i_ready", 32'(iReady), 32'h1);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0; iValid = 1'b1; iData = 4'h5; polN = 1'b0; zReady = 1'b1;
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
    @(negedge CLK);
    checkOutput("post_rst_zn", 32'(zn), 32'hA);
    checkOutput("post_rst_valid", 32'(znValid), 32'h1);
    drain(3);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__inv_pipe.md
Name: gf180mcu_fd_sc_mcu9t5v0__inv_pipe

Overview:
- Parametrised successor to the single-bit inverter cell.
- WIDTH-lane inverter followed by a DEPTH-stage elastic register pipeline with a valid/ready handshake on both sides.
- Adds a per-lane inversion mask and a per-beat runtime polarity mode, so the block works as a retimed, polarity-programmable bus driver.
- Used where bus inversion must be registered for timing closure and must honour downstream backpressure.

Parameters:
- WIDTH, 4, number of data lanes (1..64).
- DEPTH, 2, number of pipeline register stages (1..8).
- INV_MASK, {WIDTH{1'b1}}, per-lane static mask; bit=1 means the lane is invertible, bit=0 means the lane is always pass-through.
- OCC_W, $clog2(DEPTH+1), width of the occupancy output (derived; not overridden).

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- I  input  WIDTH  input data beat.
- I_VALID  input  1  input beat valid.
- I_READY  output  1  pipeline can accept a beat this cycle.
- POL_N  input  1  per-beat polarity; 1 = pass all lanes, 0 = invert lanes selected by INV_MASK. Sampled with the beat.
- ZN  output  WIDTH  output data from the last stage.
- ZN_VALID  output  1  last stage holds a valid beat.
- ZN_READY  input  1  downstream accepts the beat.
- OCC  output  OCC_W  number of valid beats currently held, 0..DEPTH.

Behaviour:
- Transform is applied at capture: stage0 data <= I ^ (INV_MASK & {WIDTH{~POL_N}}). Later stages copy data unchanged, so a change in POL_N never affects beats already in flight.
- Stage k (0..DEPTH-1) holds one data register and one valid bit. Stage DEPTH-1 drives ZN and ZN_VALID directly from registers, with no combinational path from I to ZN.
- Advance rule:
  - adv[DEPTH-1] = ZN_READY | ~valid[DEPTH-1].
  - adv[k] = adv[k+1] | ~valid[k].
  - I_READY = adv[0].
  - The ready chain is combinational; no skid buffer.
- On a cycle where adv[k] is 1:
  - valid[k] <= (k==0 ? I_VALID : valid[k-1]).
  - data[k] loads only when the incoming valid is 1; otherwise data[k] holds.
- Stalled stages (adv=0) hold both data and valid.
- Handshake:
  - A beat is accepted when I_VALID & I_READY, and delivered when ZN_VALID & ZN_READY.
  - ZN and ZN_VALID are stable while ZN_VALID=1 and ZN_READY=0.
  - I_VALID may be deasserted at any time; bubbles propagate.
- Latency: exactly DEPTH cycles from acceptance to ZN_VALID when unstalled. Throughput is 1 beat/cycle with ZN_READY held at 1.
- Ordering: strict FIFO; no beat is dropped or duplicated.
- OCC: registered.
  - Increments on accept without deliver.
  - Decrements on deliver without accept.
  - Unchanged on both or neither.
  - Never exceeds DEPTH and never underflows.
  - Always equals the popcount of the valid bits.
- Full: OCC==DEPTH with ZN_READY=0 gives I_READY=0. With ZN_READY=1, I_READY=1 in the same cycle (simultaneous accept and deliver at full is legal).
- Empty: OCC==0 gives ZN_VALID=0 and I_READY=1.
- Reset (asynchronous, any time including mid-transfer): all valid bits 0, all data registers 0, OCC=0, hence ZN=0 and ZN_VALID=0. I_READY=1 while RST is asserted and after it is released. In-flight beats are discarded. The first accept is possible on the first rising edge after RST deasserts.
- DEPTH=1: a single register stage; the same rules apply with latency 1.
- Lanes with INV_MASK=0 equal their input bit regardless of POL_N.

Test Plan:
- Reset: assert RST mid-stream with OCC=2 -> ZN=4'h0, ZN_VALID=0, OCC=0 immediately (no clock edge needed); I_READY=1.
- Streaming: WIDTH=4, DEPTH=2, POL_N=0, ZN_READY=1; feed I=4'h3,4'hA,4'hF on consecutive cycles -> ZN=4'hC,4'h5,4'h0 on cycles 2,3,4 after the first accept; OCC steady at 2.
- Polarity per beat: alternate POL_N 0/1 with I=4'h6 -> ZN alternates 4'h9/4'h6 in order. Toggle POL_N while a beat is stalled -> held ZN unchanged.
- Backpressure/full: ZN_READY=0, feed 3 beats -> first 2 accepted, I_READY=0 on the 3rd, OCC=2, ZN stable. Raise ZN_READY -> I_READY=1 that cycle, 3rd beat accepted, OCC stays 2.
- Bubbles and ordering: random I_VALID/ZN_READY for 1000 cycles -> scoreboard output equals expected XOR of inputs in order; OCC matches in-flight count every cycle.
- Mask: INV_MASK=4'b0101, POL_N=0, I=4'hF -> ZN=4'hA. With DEPTH=1, latency is 1 cycle.
